// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------------+
// | lsu_pkg : shared funct3 encodings, FSM state codes and access-fault rules   |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package lsu_pkg;

  // RISC-V load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_RESP = 3'd4;

  // Encoding and alignment legality only; range checks live in the bridge.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = we;
      F3_H:    bad = addr_lo[0];
      F3_HU:   bad = we | addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +----------------------------------------------------------------------------+
// | lsu_lane_align : load lane extraction/extension and sub-word store merge    |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   load_data = {24'h000000, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   load_data = {16'h0000, w_half};
      default: load_data = rdata;
    endcase
  end

  // Byte stores hit one lane; anything else reaching here is a halfword store.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam int LANE = i;
    logic       w_hit;
    logic [7:0] w_src;

    assign w_hit = (funct3 == F3_B) ? (addr_lo == 2'(LANE))
                                    : (addr_lo[1] == 1'(LANE / 2));
    assign w_src = ((funct3 == F3_B) || ((LANE % 2) == 0)) ? wdata[7:0] : wdata[15:8];
    assign merged[8*LANE +: 8] = w_hit ? w_src : rdata[8*LANE +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ram_bridge.sv
// +----------------------------------------------------------------------------+
// | lsu_ram_bridge : single-outstanding LSU to word-RAM bridge with RMW stores  |
// | Build option : define LSU_BOUNDS_CHECK_EN to fault word indices >= SIZE     |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module lsu_ram_bridge
  import lsu_pkg::*;
#(
  parameter int SIZE = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_we,
  input  logic [31:0] ram_rdata
);

  localparam logic [31:0] SIZE_W = 32'(SIZE);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_oob;
  logic        w_fault;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob = ({2'b00, req_addr[31:2]} >= SIZE_W);
`else
  // Without the check the RAM simply wraps the index modulo its depth.
  logic size_unused;
  assign size_unused = ^SIZE_W;
  assign w_oob       = 1'b0;
`endif

  assign w_fault = access_fault(req_we, req_funct3, req_addr[1:0]) | w_oob;

  lsu_lane_align u_lane_align (
    .rdata     (ram_rdata),
    .addr_lo   (r_addr[1:0]),
    .funct3    (r_funct3),
    .wdata     (r_wdata[15:0]),
    .load_data (w_load_data),
    .merged    (w_merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= w_fault;
            if (w_fault)
              r_state <= ST_RESP;
            else if (req_we && (req_funct3 == F3_W))
              r_state <= ST_WR;
            else
              r_state <= ST_RD;
          end
        end
        ST_RD:   r_state <= ST_DATA;
        ST_DATA: begin
          if (!r_we)
            r_rsp_rdata <= w_load_data;
          r_state <= ST_RESP;
        end
        ST_WR:   r_state <= ST_RESP;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM-facing outputs decode straight from state so reset silences them at once.
  always_comb begin
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    ram_we    = 4'b0000;
    case (r_state)
      ST_RD: begin
        ram_addr = {2'b00, r_addr[31:2]};
      end
      ST_DATA: begin
        ram_addr = {2'b00, r_addr[31:2]};
        if (r_we) begin
          ram_wdata = w_merged;
          ram_we    = 4'b1111;
        end
      end
      ST_WR: begin
        ram_addr  = {2'b00, r_addr[31:2]};
        ram_wdata = r_wdata;
        ram_we    = 4'b1111;
      end
      default: begin
        ram_addr  = 32'h0;
        ram_wdata = 32'h0;
        ram_we    = 4'b0000;
      end
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ram_bridge.sv
// +----------------------------------------------------------------------------+
// | tb_lsu_ram_bridge : directed table, reset corner case and random traffic    |
// | Rev 1.0 : initial release                                                   |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_lsu_ram_bridge;

  localparam int SIZE = 512;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_we     = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr   = 32'h0;
  logic [31:0] req_wdata  = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem     [SIZE];
  logic [31:0] ref_mem [SIZE];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [18];

  always #5 clk = ~clk;

  lsu_ram_bridge #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous RAM with one-cycle read latency; the index wraps at its depth.
  always @(posedge clk) begin
    if (ram_we == 4'hF) mem[int'(ram_addr % SIZE)] <= ram_wdata;
    ram_rdata <= mem[int'(ram_addr % SIZE)];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr / 4 >= SIZE) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Reference: byte-lane arithmetic on a word array, updated in program order.
  task automatic ref_apply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output logic [31:0] new_word);
    int          idx;
    int          off;
    logic [31:0] word, mask, val, v;
    err      = ref_fault(we, f3, addr);
    rdata    = 32'h0;
    new_word = 32'h0;
    lat      = 1;
    if (err) return;
    idx  = int'((addr / 4) % SIZE);
    off  = int'(addr % 4);
    word = ref_mem[idx];
    if (we) begin
      if (f3 == 3'd0) begin
        mask = 32'hFF << (8 * off);   val = (wdata & 32'hFF) << (8 * off);
      end else if (f3 == 3'd1) begin
        mask = 32'hFFFF << (8 * off); val = (wdata & 32'hFFFF) << (8 * off);
      end else begin
        mask = 32'hFFFF_FFFF;         val = wdata;
      end
      new_word     = (word & ~mask) | val;
      ref_mem[idx] = new_word;
      lat          = (f3 == 3'd2) ? 2 : 3;
    end else begin
      v = word >> (8 * off);
      case (f3)
        3'd0:    begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
        3'd4:    v = v & 32'hFF;
        3'd1:    begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
        3'd5:    v = v & 32'hFFFF;
        default: v = word;
      endcase
      rdata = v;
      lat   = 3;
    end
  endtask

  // One request through the DUT, checked against the reference model.
  task automatic transact(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          output logic [31:0] got_rdata, output logic got_err, output int got_lat);
    logic [31:0] e_rdata, e_word;
    logic        e_err;
    int          e_lat;
    bit          seen, wrote;
    logic [31:0] wr_idx, wr_data;
    logic [3:0]  wr_we;
    ref_apply(we, f3, addr, wdata, e_rdata, e_err, e_lat, e_word);
    seen = 0; wrote = 0; wr_idx = 0; wr_data = 0; wr_we = 0;
    got_rdata = 32'hX; got_err = 1'bX; got_lat = 0;
    @(negedge clk);
    chk({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    if (hold) begin
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h5A5A_5A5A;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (ram_we != 4'h0) begin
        wrote = 1; wr_idx = ram_addr; wr_data = ram_wdata; wr_we = ram_we;
      end
      if (rsp_valid) begin
        seen = 1; got_lat = i; got_rdata = rsp_rdata; got_err = rsp_err;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk({name, " rsp seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({name, " latency"}, 32'(got_lat), 32'(e_lat));
    chk({name, " err"}, 32'(got_err), 32'(e_err));
    chk({name, " rdata"}, got_rdata, e_rdata);
    chk({name, " wrote"}, 32'(wrote), 32'(we && !e_err));
    if (we && !e_err) begin
      chk({name, " wr idx"}, wr_idx, addr >> 2);
      chk({name, " wr data"}, wr_data, e_word);
      chk({name, " wr we"}, 32'(wr_we), 32'hF);
    end
    @(negedge clk);
    chk({name, " pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g_rdata;
    logic        g_err;
    int          g_lat;
    logic [2:0]  pool [5];
    int          bad;

    for (int i = 0; i < SIZE; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    vt[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0, 2};
    vt[1]  = '{1'b0, 3'd0, 32'h13,  32'h0,         32'hFFFF_FFDE, 1'b0, 3};
    vt[2]  = '{1'b0, 3'd4, 32'h13,  32'h0,         32'h0000_00DE, 1'b0, 3};
    vt[3]  = '{1'b1, 3'd1, 32'h12,  32'h0000_1234, 32'h0,         1'b0, 3};
    vt[4]  = '{1'b0, 3'd2, 32'h10,  32'h0,         32'h1234_BEEF, 1'b0, 3};
    vt[5]  = '{1'b0, 3'd2, 32'h11,  32'h0,         32'h0,         1'b1, 1};
    vt[6]  = '{1'b0, 3'd1, 32'h12,  32'h0,         32'h0000_1234, 1'b0, 3};
    vt[7]  = '{1'b0, 3'd1, 32'h10,  32'h0,         32'hFFFF_BEEF, 1'b0, 3};
    vt[8]  = '{1'b0, 3'd5, 32'h10,  32'h0,         32'h0000_BEEF, 1'b0, 3};
    vt[9]  = '{1'b0, 3'd5, 32'h11,  32'h0,         32'h0,         1'b1, 1};
    vt[10] = '{1'b0, 3'd3, 32'h10,  32'h0,         32'h0,         1'b1, 1};
    vt[11] = '{1'b1, 3'd4, 32'h10,  32'h1111_1111, 32'h0,         1'b1, 1};
    vt[12] = '{1'b1, 3'd1, 32'h13,  32'h2222_2222, 32'h0,         1'b1, 1};
    vt[13] = '{1'b1, 3'd0, 32'h11,  32'hFFFF_FFA5, 32'h0,         1'b0, 3};
    vt[14] = '{1'b0, 3'd2, 32'h10,  32'h0,         32'h1234_A5EF, 1'b0, 3};
`ifdef LSU_BOUNDS_CHECK_EN
    vt[15] = '{1'b1, 3'd2, 32'h800, 32'hCAFE_F00D, 32'h0,         1'b1, 1};
    vt[16] = '{1'b0, 3'd2, 32'h0,   32'h0,         32'h0,         1'b0, 3};
`else
    vt[15] = '{1'b1, 3'd2, 32'h800, 32'hCAFE_F00D, 32'h0,         1'b0, 2};
    vt[16] = '{1'b0, 3'd2, 32'h0,   32'h0,         32'hCAFE_F00D, 1'b0, 3};
`endif
    vt[17] = '{1'b0, 3'd2, 32'h10,  32'h0,         32'h1234_A5EF, 1'b0, 3};

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      transact(nm, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, 1'b0, g_rdata, g_err, g_lat);
      chk({nm, " tbl rdata"}, g_rdata, vt[i].exp_rdata);
      chk({nm, " tbl err"}, 32'(g_err), 32'(vt[i].exp_err));
      chk({nm, " tbl lat"}, 32'(g_lat), 32'(vt[i].exp_lat));
    end

    // Reset during the DATA cycle of a byte store abandons it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst mid ram_we in DATA", 32'(ram_we), 32'hF);
    #1 reset_n = 1'b0;
    #1;
    chk("rst mid ram_we", 32'(ram_we), 32'd0);
    chk("rst mid ram_addr", ram_addr, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("rst mid no rsp", 32'(bad), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst mid ready", 32'(req_ready), 32'd1);
    chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
    transact("rst readback", 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, g_rdata, g_err, g_lat);
    chk("rst readback value", g_rdata, 32'h0);

    // Random traffic, occasionally holding req_valid high while busy
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          r, word;
      we   = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 19));
      f3   = (r < 17) ? pool[r % 5] : 3'($urandom_range(0, 7));
      word = int'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) word += SIZE * int'($urandom_range(1, 3));
      addr = 32'(word) * 4 + 32'($urandom_range(0, 3));
      transact($sformatf("rnd%0d", n), we, f3, addr, $urandom, ($urandom_range(0, 3) == 0),
               g_rdata, g_err, g_lat);
    end

    bad = 0;
    for (int i = 0; i < SIZE; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("ram image words differing", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_ram_bridge.md
LSU_RAM_BRIDGE -- requirements
Module: lsu_ram_bridge

Interface
REQ-001 SHALL have parameter SIZE, default 512, meaning RAM depth in 32-bit words (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  bridge can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  output  1  access rejected; qualified by rsp_valid.
REQ-013 SHALL have port ram_addr  output  32  word index to RAM, zero-extended.
REQ-014 SHALL have port ram_wdata  output  32  full word to RAM.
REQ-015 SHALL have port ram_we  output  4  RAM write enable; only 4'b0000 or 4'b1111.
REQ-016 SHALL have port ram_rdata  input  32  RAM read data; valid the cycle after the address edge.

Function
REQ-017 SHALL accept a request on a clock edge where req_valid and req_ready are both 1, capturing all req_* fields.
REQ-018 SHALL assert req_ready only in state IDLE; one request is in flight at a time.
REQ-019 SHALL implement states IDLE, RD, DATA, WR, RESP.
REQ-020 SHALL transition on acceptance: load or SB/SH -> RD; SW -> WR; error -> RESP.
REQ-021 SHALL transition RD -> DATA -> RESP and WR -> RESP; RESP -> IDLE unconditionally.
REQ-022 SHALL drive ram_addr = captured addr[31:2] in RD, DATA and WR, ram_we = 0 in every state except DATA(store) and WR.
REQ-023 SHALL, in DATA for a load, register the selected lane of ram_rdata, sign-extended for B/H and zero-extended for BU/HU.
REQ-024 SHALL, in DATA for SB/SH, drive ram_wdata = ram_rdata with lane(s) addr[1:0] replaced by req_wdata[7:0]/[15:0], and ram_we = 4'b1111 (read-modify-write).
REQ-025 SHALL, in WR, drive ram_wdata = req_wdata and ram_we = 4'b1111.
REQ-026 SHALL assert rsp_valid exactly one cycle, in RESP: 3 cycles after acceptance for load/SB/SH, 2 for SW, 1 for errors.
REQ-027 SHALL flag an error (rsp_err = 1, no RAM write) for H/HU with addr[0] = 1, W with addr[1:0] != 0, funct3 011/110/111 on loads, or funct3 other than 000/001/010 on stores.
REQ-028 SHALL ignore req_valid while req_ready = 0; rsp has no backpressure.

Reset
REQ-029 SHALL, while reset_n = 0, force state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, ram_we 0, ram_addr 0, ram_wdata 0.
REQ-030 SHALL abandon an in-flight request on reset with no RAM write and no response.

Configuration
REQ-031 SHALL, with LSU_BOUNDS_CHECK_EN defined, flag an error for addr[31:2] >= SIZE.
REQ-032 SHALL, without LSU_BOUNDS_CHECK_EN, perform no bounds check, so addresses wrap modulo SIZE words at the RAM.

Structure
REQ-033 SHALL take funct3 encodings and the state enum from shared package lsu_pkg.
REQ-034 SHALL place lane extraction and merge logic in combinational sub-module lsu_lane_align.

Verification
REQ-035 SHALL test SW: SW 0x0000_0010 data 0xDEADBEEF -> ram_we 1111 at word 4, rsp_valid 2 cycles later, rsp_err 0.
REQ-036 SHALL test LB/LBU: after REQ-035, LB 0x13 -> rsp_rdata 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
REQ-037 SHALL test SH read-modify-write: SH 0x12 data 0x1234 -> word 4 becomes 0x1234BEEF; LW 0x10 returns it.
REQ-038 SHALL test misaligned access: LW 0x11 -> rsp_err 1 one cycle after acceptance, ram_we never nonzero.
REQ-039 SHALL test bounds: with LSU_BOUNDS_CHECK_EN and SIZE 512, SW 0x800 -> rsp_err 1; without it, the store lands at word 0.
REQ-040 SHALL test reset mid-operation: reset_n low during DATA of SB -> ram_we 0 immediately, no rsp_valid, req_ready 1 after release.
